seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 36 +++
 rtl/seg_scan_timer.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: state encodings,
// blank pattern and the hex decode table (active-low, g..a).
package seg_scan_ctrl_pkg;

  localparam int CNT_W = 20;

  localparam logic [0:0] ST_GAP  = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n is the segment pattern for hex digit n; bit 6 = g, bit 0 = a.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Phase counter for the scanner: counts cycles of the current SHOW or GAP
// phase and flags the last cycle of that phase.
module seg_scan_timer
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GAP_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic show_i,
  output logic phase_end_o
);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last_cnt;

  assign last_cnt    = show_i ? SHOW_LAST : GAP_LAST;
  assign phase_end_o = (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (phase_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller with frame-synchronous
// display update. Define SEG_LZ_BLANK_EN to blank leading zero digits.
//
// state | meaning
// GAP   | all digits off, guard between digits; last GAP before digit 0 is the frame boundary
// SHOW  | digit dig enabled, segments show decoded nibble of disp
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  an_n,
  output logic [7:1]  seven,
  output logic        frame_done
);

  logic [0:0]  state_q, state_d;
  logic [1:0]  dig_q, dig_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  an_n_q, an_n_d;
  logic [6:0]  seven_q, seven_d;
  logic        phase_end;
  logic        boundary;
  logic        lz_blank;

  seg_scan_timer #(
    .CLK_DIV(CLK_DIV),
    .GAP_CYC(GAP_CYC)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .show_i     (state_q == ST_SHOW),
    .phase_end_o(phase_end)
  );

  assign boundary = (state_q == ST_GAP) && phase_end && (dig_q == 2'd0);
  // Gated by reset so a one-cycle GAP cannot pulse while reset is held.
  assign frame_done = boundary && !reset;

  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (phase_end) begin
      if (state_q == ST_GAP) begin
        state_d = ST_SHOW;
      end else begin
        state_d = ST_GAP;
        dig_d   = dig_q + 2'd1;
      end
    end

    if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end

    // A load on the boundary bypasses pend and lands directly in disp.
    if (boundary) begin
      if (load)          disp_d = value;
      else if (pend_v_q) disp_d = pend_q;
      pend_v_d = 1'b0;
    end
  end

  always_comb begin
    lz_blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    case (dig_d)
      2'd3:    lz_blank = (disp_d[15:12] == 4'h0);
      2'd2:    lz_blank = (disp_d[15:8]  == 8'h00);
      2'd1:    lz_blank = (disp_d[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
`endif
  end

  // Outputs are computed from next-state so enables and segments move together.
  always_comb begin
    an_n_d  = 4'b1111;
    seven_d = SEG_BLANK;
    if (state_d == ST_SHOW) begin
      an_n_d  = ~(4'b0001 << dig_d);
      seven_d = lz_blank ? SEG_BLANK : seg_decode(disp_d[{dig_d, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_GAP;
      dig_q    <= 2'd0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_n_q   <= 4'b1111;
      seven_q  <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_n_q   <= an_n_d;
      seven_q  <= seven_d;
    end
  end

  assign an_n  = an_n_q;
  assign seven = seven_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with CLK_DIV=4, GAP_CYC=2 (24-cycle frame).
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 2;
  localparam int NVEC    = 11;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  typedef logic [3:0][6:0] seg4_t;
  typedef struct packed {
    logic [15:0] v0;
    int          k0;
    logic [15:0] v1;
    int          k1;
    seg4_t       seg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  an_n;
  logic [7:1]  seven;
  logic        frame_done;

  int    checks = 0;
  int    errors = 0;
  seg4_t exp_q[$];
  vec_t  vecs[NVEC];
  seg4_t zf;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .an_n      (an_n),
    .seven     (seven),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] v0, input int k0,
                              input logic [15:0] v1, input int k1, input seg4_t seg);
    vec_t v;
    v.v0 = v0; v.k0 = k0; v.v1 = v1; v.k1 = k1; v.seg = seg;
    return v;
  endfunction

  // Entered at the sample point of a frame-boundary cycle; runs one 24-cycle frame.
  // Load at k=0 hits the boundary itself and replaces the frame about to be shown.
  task automatic run_frame(input int row, input vec_t v);
    seg4_t      cur;
    logic [3:0] e_an;
    logic [6:0] e_sg;
    int         j, d, p;
    if (v.k0 == 0) begin
      load  = 1'b1;
      value = v.v0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      exp_q.push_front(v.seg);
    end
    cur = '0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard row %0d: got empty queue expected an entry", row);
    end else begin
      cur = exp_q.pop_front();
    end
    exp_q.push_back(v.seg);
    for (int k = 1; k <= 24; k++) begin
      tick();
      load = 1'b0;
      if (k == 1 && v.k0 == 0)
        chk($sformatf("pend_v_after_boundary_load row%0d", row), {31'd0, dut.pend_v_q}, 32'd0);
      j = k - 1;
      d = j / 6;
      p = j % 6;
      e_an = (p < 4) ? ~(4'b0001 << d) : 4'b1111;
      e_sg = (p < 4) ? cur[d] : BL;
      chk($sformatf("an_n row%0d k%0d", row, k), {28'd0, an_n}, {28'd0, e_an});
      chk($sformatf("seven row%0d k%0d", row, k), {25'd0, seven}, {25'd0, e_sg});
      chk($sformatf("frame_done row%0d k%0d", row, k), {31'd0, frame_done}, {31'd0, (k == 24)});
      if (k < 24 && (k == v.k0 || k == v.k1)) begin
        load  = 1'b1;
        value = (k == v.k0) ? v.v0 : v.v1;
      end
    end
  endtask

  initial begin
`ifdef SEG_LZ_BLANK_EN
    zf = {BL, BL, BL, S0};
    vecs[4] = mk(16'h0050, 20, 16'h0, -1, {BL, BL, S5, S0});
    vecs[7] = mk(16'h00C3, 0,  16'h0, -1, {BL, BL, SC, S3});
    vecs[9] = mk(16'h0306, 12, 16'h0, -1, {BL, S3, S0, S6});
    vecs[10] = mk(16'h0, -1, 16'h0, -1, {BL, S3, S0, S6});
`else
    zf = {S0, S0, S0, S0};
    vecs[4] = mk(16'h0050, 20, 16'h0, -1, {S0, S0, S5, S0});
    vecs[7] = mk(16'h00C3, 0,  16'h0, -1, {S0, S0, SC, S3});
    vecs[9] = mk(16'h0306, 12, 16'h0, -1, {S0, S3, S0, S6});
    vecs[10] = mk(16'h0, -1, 16'h0, -1, {S0, S3, S0, S6});
`endif
    vecs[0] = mk(16'h0,    -1, 16'h0,    -1, zf);
    vecs[1] = mk(16'h12AF, 10, 16'h0,    -1, {S1, S2, SA, SF});
    vecs[2] = mk(16'h0,    -1, 16'h0,    -1, {S1, S2, SA, SF});
    vecs[3] = mk(16'h1111, 3,  16'h2222, 15, {S2, S2, S2, S2});
    vecs[5] = mk(16'h0000, 1,  16'h0,    -1, zf);
    vecs[6] = mk(16'hE9B8, 7,  16'h0,    -1, {SE, S9, SB, S8});
    vecs[8] = mk(16'h4C7D, 22, 16'h0,    -1, {S4, SC, S7, SD});

    reset = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    repeat (3) tick();
    chk("reset an_n", {28'd0, an_n}, 32'hF);
    chk("reset seven", {25'd0, seven}, 32'h7F);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    exp_q.push_back(zf);
    tick();
    chk("first boundary frame_done", {31'd0, frame_done}, 32'd1);
    chk("first boundary an_n", {28'd0, an_n}, 32'hF);

    for (int i = 0; i < NVEC; i++) run_frame(i, vecs[i]);

    // Reset pulse in the middle of digit 2's SHOW, with a pending load outstanding.
    for (int k = 1; k <= 14; k++) begin
      tick();
      load = (k == 4);
      if (k == 4) value = 16'h7777;
    end
    chk("mid d2 an_n", {28'd0, an_n}, 32'hB);
    reset = 1'b1;
    tick();
    chk("reset mid-show an_n", {28'd0, an_n}, 32'hF);
    chk("reset mid-show seven", {25'd0, seven}, 32'h7F);
    chk("reset mid-show frame_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post-reset boundary frame_done", {31'd0, frame_done}, 32'd1);
    chk("post-reset boundary an_n", {28'd0, an_n}, 32'hF);
    exp_q.delete();
    exp_q.push_back(zf);
    run_frame(100, mk(16'h0, -1, 16'h0, -1, zf));
    run_frame(101, mk(16'h0, -1, 16'h0, -1, zf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
